// File: rtl/jtdd_pkg.sv
// Shared definitions for the ROM arbiter: FSM encoding, default SDRAM offsets
// and requester indices (char=0, obj=1, scr=2, which is also the round-robin order).
package jtdd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } state_t;

   localparam logic [21:0] DEF_CHAR_OFFSET = 22'h00_0000;
   localparam logic [21:0] DEF_SCR_OFFSET  = 22'h00_4000;
   localparam logic [21:0] DEF_OBJ_OFFSET  = 22'h02_4000;

   localparam logic [1:0] ID_CHAR = 2'd0;
   localparam logic [1:0] ID_OBJ  = 2'd1;
   localparam logic [1:0] ID_SCR  = 2'd2;

   function automatic logic [2:0] onehot3(input logic [1:0] id);
      return 3'b001 << id;
   endfunction

endpackage

// File: rtl/jtdd_rom_slot.sv
// One ROM requester: latched word address, data register and valid flag.
// A requester is pending while its current address differs from the cached one.
module jtdd_rom_slot #(
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] addr,
   input  logic          cs,
   input  logic          grant,
   input  logic          fill,
   input  logic [15:0]   din,
   output logic [15:0]   data,
   output logic          pending,
   output logic          ok
);

   logic [AW-1:0] latched;
   logic          valid;
   logic          match;

   assign match   = addr == latched;
   assign pending = cs & (~valid | ~match);
   // cs low only masks ok; the cached word survives for the next access
   assign ok      = cs & valid & match;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latched <= '0;
         data    <= '0;
         valid   <= 1'b0;
      end else if (grant) begin
         latched <= addr;
         valid   <= 1'b0;
      end else if (fill) begin
         data    <= din;
         valid   <= 1'b1;
      end
   end

endmodule

// File: rtl/jtdd_rom_arb.sv
// SDRAM arbiter for the char/scroll/object ROMs with a one-word cache per requester.
// Grant policy: fixed char > obj > scr, or round-robin when JTDD_ROM_RR_EN is defined.
module jtdd_rom_arb
   import jtdd_pkg::*;
#(
   parameter logic [21:0] CHAR_OFFSET = DEF_CHAR_OFFSET,
   parameter logic [21:0] SCR_OFFSET  = DEF_SCR_OFFSET,
   parameter logic [21:0] OBJ_OFFSET  = DEF_OBJ_OFFSET
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [14:0] char_addr,
   input  logic        char_cs,
   output logic [7:0]  char_data,
   output logic        char_ok,
   input  logic [16:0] scr_addr,
   input  logic        scr_cs,
   output logic [15:0] scr_data,
   output logic        scr_ok,
   input  logic [17:0] obj_addr,
   input  logic        obj_cs,
   output logic [15:0] obj_data,
   output logic        obj_ok,
   output logic [21:0] sdram_addr,
   output logic        sdram_req,
   input  logic        sdram_ack,
   input  logic        sdram_rdy,
   input  logic [15:0] sdram_dout
);

   state_t      state, state_nxt;
   logic [1:0]  gnt, sel;
   logic [2:0]  pend, grant, fill;
   logic [21:0] addr_nxt;
   logic [15:0] char_word;

   jtdd_rom_slot #(.AW(14)) u_char (
      .clk(clk), .rst(rst), .addr(char_addr[14:1]), .cs(char_cs),
      .grant(grant[ID_CHAR]), .fill(fill[ID_CHAR]), .din(sdram_dout),
      .data(char_word), .pending(pend[ID_CHAR]), .ok(char_ok)
   );

   jtdd_rom_slot #(.AW(18)) u_obj (
      .clk(clk), .rst(rst), .addr(obj_addr), .cs(obj_cs),
      .grant(grant[ID_OBJ]), .fill(fill[ID_OBJ]), .din(sdram_dout),
      .data(obj_data), .pending(pend[ID_OBJ]), .ok(obj_ok)
   );

   jtdd_rom_slot #(.AW(17)) u_scr (
      .clk(clk), .rst(rst), .addr(scr_addr), .cs(scr_cs),
      .grant(grant[ID_SCR]), .fill(fill[ID_SCR]), .din(sdram_dout),
      .data(scr_data), .pending(pend[ID_SCR]), .ok(scr_ok)
   );

   // byte lane follows the live address, so toggling bit 0 needs no new fetch
   assign char_data = char_addr[0] ? char_word[15:8] : char_word[7:0];
   assign sdram_req = state == ST_REQ;

`ifdef JTDD_ROM_RR_EN
   logic [1:0] rr_ptr;
   logic [2:0] idx;
   logic       found;

   // rr_ptr names the requester checked first; it moves past each grant
   always_comb begin
      sel   = ID_CHAR;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < 3; k++) begin
         idx = {1'b0, rr_ptr} + 3'(k);
         if (idx >= 3'd3) idx = idx - 3'd3;
         if (!found && pend[idx[1:0]]) begin
            found = 1'b1;
            sel   = idx[1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rr_ptr <= ID_CHAR;
      else if (|grant) rr_ptr <= (sel == ID_SCR) ? ID_CHAR : sel + 2'd1;
   end
`else
   always_comb sel = pend[ID_CHAR] ? ID_CHAR : (pend[ID_OBJ] ? ID_OBJ : ID_SCR);
`endif

   // offsets wrap modulo 2^22 by plain 22-bit addition
   always_comb begin
      case (sel)
         ID_CHAR: addr_nxt = CHAR_OFFSET + 22'(char_addr[14:1]);
         ID_OBJ:  addr_nxt = OBJ_OFFSET  + 22'(obj_addr);
         default: addr_nxt = SCR_OFFSET  + 22'(scr_addr);
      endcase
   end

   always_comb begin
      state_nxt = state;
      grant     = '0;
      fill      = '0;
      case (state)
         ST_IDLE: if (|pend) begin
            grant     = onehot3(sel);
            state_nxt = ST_REQ;
         end
         ST_REQ:  if (sdram_ack) state_nxt = ST_WAIT;
         ST_WAIT: if (sdram_rdy) begin
            fill      = onehot3(gnt);
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         gnt        <= ID_CHAR;
         sdram_addr <= '0;
      end else begin
         state <= state_nxt;
         if (|grant) begin
            gnt        <= sel;
            sdram_addr <= addr_nxt;
         end
      end
   end

endmodule

// File: tb/tb_jtdd_rom_arb.sv
// Bench for jtdd_rom_arb: table vectors, hand-written corner sequences and a
// randomized run against a cache-level reference model of the three requesters.
module tb_jtdd_rom_arb;

   localparam logic [21:0] C_OFF = 22'h00_0000;
   localparam logic [21:0] S_OFF = 22'h00_4000;
   localparam logic [21:0] O_OFF = 22'h3F_0001;

   logic        clk = 1'b0, rst = 1'b1;
   logic [14:0] char_addr = '0;
   logic        char_cs = 1'b0, char_ok;
   logic [7:0]  char_data;
   logic [16:0] scr_addr = '0;
   logic        scr_cs = 1'b0, scr_ok;
   logic [15:0] scr_data;
   logic [17:0] obj_addr = '0;
   logic        obj_cs = 1'b0, obj_ok;
   logic [15:0] obj_data;
   logic [21:0] sdram_addr;
   logic        sdram_req;
   logic        sdram_ack = 1'b0, sdram_rdy = 1'b0;
   logic [15:0] sdram_dout = '0;

   int tests = 0, fails = 0;

   jtdd_rom_arb #(.CHAR_OFFSET(C_OFF), .SCR_OFFSET(S_OFF), .OBJ_OFFSET(O_OFF)) dut (
      .clk(clk), .rst(rst),
      .char_addr(char_addr), .char_cs(char_cs), .char_data(char_data), .char_ok(char_ok),
      .scr_addr(scr_addr), .scr_cs(scr_cs), .scr_data(scr_data), .scr_ok(scr_ok),
      .obj_addr(obj_addr), .obj_cs(obj_cs), .obj_data(obj_data), .obj_ok(obj_ok),
      .sdram_addr(sdram_addr), .sdram_req(sdram_req), .sdram_ack(sdram_ack),
      .sdram_rdy(sdram_rdy), .sdram_dout(sdram_dout)
   );

   always #5 clk = ~clk;

   // reference model: per requester 0=char 1=obj 2=scr
   logic [21:0] m_lat[3];
   logic [15:0] m_dat[3];
   bit          m_val[3];
   int          m_ptr;
   logic [15:0] ovr;
   bit          use_ovr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 3; r++) begin
         m_lat[r] = '0; m_dat[r] = '0; m_val[r] = 0;
      end
      m_ptr = 0;
   endtask

   function automatic logic [21:0] cur_word(input int r);
      case (r)
         0: return 22'(char_addr >> 1);
         1: return 22'(obj_addr);
         default: return 22'(scr_addr);
      endcase
   endfunction

   function automatic bit cur_cs(input int r);
      case (r)
         0: return char_cs;
         1: return obj_cs;
         default: return scr_cs;
      endcase
   endfunction

   function automatic logic [21:0] m_off(input int r);
      case (r)
         0: return C_OFF;
         1: return O_OFF;
         default: return S_OFF;
      endcase
   endfunction

   function automatic logic [21:0] exp_addr(input int r);
      return 22'((int'(m_off(r)) + int'(cur_word(r))) % (1 << 22));
   endfunction

   function automatic bit m_pend(input int r);
      return cur_cs(r) && (!m_val[r] || m_lat[r] != cur_word(r));
   endfunction

   function automatic int m_pick();
      int start, r;
`ifdef JTDD_ROM_RR_EN
      start = m_ptr;
`else
      start = 0;
`endif
      for (int k = 0; k < 3; k++) begin
         r = (start + k) % 3;
         if (m_pend(r)) return r;
      end
      return -1;
   endfunction

   function automatic logic [15:0] mem(input logic [21:0] a);
      return a[15:0] ^ {a[21:16], a[9:0]} ^ 16'h1D2B;
   endfunction

   function automatic logic dut_ok(input int r);
      case (r)
         0: return char_ok;
         1: return obj_ok;
         default: return scr_ok;
      endcase
   endfunction

   task automatic check_model(input string tag);
      logic [15:0] w;
      #1;
      for (int r = 0; r < 3; r++) begin
         w = m_dat[r];
         chk($sformatf("%s_ok%0d", tag, r), dut_ok(r),
             cur_cs(r) && m_val[r] && (m_lat[r] == cur_word(r)));
         case (r)
            0: chk($sformatf("%s_cdata", tag), char_data, char_addr[0] ? w[15:8] : w[7:0]);
            1: chk($sformatf("%s_odata", tag), obj_data, w);
            default: chk($sformatf("%s_sdata", tag), scr_data, w);
         endcase
      end
   endtask

   task automatic wait_req(output bit got);
      int n = 0;
      while (sdram_req !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      got = (sdram_req === 1'b1);
   endtask

   task automatic pulse_ack();
      sdram_ack = 1'b1;
      @(negedge clk);
      sdram_ack = 1'b0;
   endtask

   task automatic pulse_rdy(input logic [21:0] a, output logic [15:0] d);
      d = use_ovr ? ovr : mem(a);
      sdram_rdy = 1'b1; sdram_dout = d;
      @(negedge clk);
      sdram_rdy = 1'b0;
   endtask

   task automatic serve(input int ad, input int rd, output logic [21:0] a,
                        output logic [15:0] d, output bit got);
      wait_req(got);
      a = sdram_addr;
      d = '0;
      if (!got) return;
      repeat (ad) @(negedge clk);
      pulse_ack();
      repeat (rd) @(negedge clk);
      pulse_rdy(a, d);
   endtask

   // one model-predicted transaction (or none, when nothing is pending)
   task automatic transact(input int ad, input int rd, output logic [21:0] a);
      int g;
      logic [21:0] ea;
      logic [15:0] d;
      bit got;
      #1;
      g = m_pick();
      a = '0;
      if (g < 0) begin
         repeat (3) begin
            @(negedge clk);
            chk("idle_no_req", sdram_req, 1'b0);
         end
         return;
      end
      ea = exp_addr(g);
      m_lat[g] = cur_word(g); m_val[g] = 0;
      m_ptr = (g + 1) % 3;
      serve(ad, rd, a, d, got);
      chk("req_seen", got, 1'b1);
      chk("sdram_addr", a, ea);
      if (got) begin
         m_dat[g] = d; m_val[g] = 1;
      end
      check_model("post");
   endtask

   typedef struct {
      int          r;
      logic [14:0] ca;
      logic [16:0] sa;
      logic [17:0] oa;
      logic [15:0] dout;
      logic [21:0] eaddr;
      logic [15:0] edata;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [21:0] a;
      logic [21:0] seq[3];
      logic [15:0] d;
      bit got;

      vecs[0] = '{0, 15'h0003, 17'h0,     18'h0,     16'hA55A, 22'h000001, 16'h00A5};
      vecs[1] = '{2, 15'h0,    17'h00010, 18'h0,     16'h1234, 22'h004010, 16'h1234};
      vecs[2] = '{1, 15'h0,    17'h0,     18'h3FFFF, 16'hBEEF, 22'h030000, 16'hBEEF};
      vecs[3] = '{0, 15'h7FFE, 17'h0,     18'h0,     16'h0F1E, 22'h003FFF, 16'h001E};
      vecs[4] = '{2, 15'h0,    17'h1FFFF, 18'h0,     16'hCAFE, 22'h023FFF, 16'hCAFE};
      vecs[5] = '{1, 15'h0,    17'h0,     18'h0,     16'h0001, 22'h3F0001, 16'h0001};

      model_reset();
      use_ovr = 0; ovr = '0;

      // reset state
      #1;
      chk("rst_req", sdram_req, 1'b0);
      chk("rst_addr", sdram_addr, 22'h0);
      chk("rst_ok", {char_ok, obj_ok, scr_ok}, 3'b000);
      chk("rst_data", {char_data, obj_data, scr_data}, 40'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // single-requester vectors: offsets, wrap, byte select
      for (int i = 0; i < 6; i++) begin
         char_cs = (vecs[i].r == 0); obj_cs = (vecs[i].r == 1); scr_cs = (vecs[i].r == 2);
         char_addr = vecs[i].ca; scr_addr = vecs[i].sa; obj_addr = vecs[i].oa;
         use_ovr = 1; ovr = vecs[i].dout;
         transact(2, 3, a);
         chk($sformatf("vec%0d_addr", i), a, vecs[i].eaddr);
         chk($sformatf("vec%0d_ok", i), dut_ok(vecs[i].r), 1'b1);
         case (vecs[i].r)
            0: chk($sformatf("vec%0d_data", i), char_data, vecs[i].edata);
            1: chk($sformatf("vec%0d_data", i), obj_data, vecs[i].edata);
            default: chk($sformatf("vec%0d_data", i), scr_data, vecs[i].edata);
         endcase
      end
      use_ovr = 0;

      // cached char word: cs gating and byte swap without refetch
      char_cs = 0; obj_cs = 0; scr_cs = 0; char_addr = 15'h7FFE;
      #1 chk("cs_off_ok", char_ok, 1'b0);
      @(negedge clk);
      char_cs = 1;
      #1 chk("hit_ok_lo", char_ok, 1'b1);
      chk("hit_data_lo", char_data, 8'h1E);
      @(negedge clk);
      char_addr = 15'h7FFF;
      #1 chk("hit_ok_hi", char_ok, 1'b1);
      chk("hit_data_hi", char_data, 8'h0F);
      repeat (3) begin
         @(negedge clk);
         chk("hit_no_req", sdram_req, 1'b0);
      end

      // all three pending at once
      char_addr = 15'h0100; obj_addr = 18'h00200; scr_addr = 17'h00300;
      char_cs = 1; obj_cs = 1; scr_cs = 1;
      for (int i = 0; i < 3; i++) transact(1, 1, seq[i]);
`ifdef JTDD_ROM_RR_EN
      chk("order0", seq[0], 22'h004300);
      chk("order1", seq[1], 22'h000080);
      chk("order2", seq[2], 22'h3F0201);
`else
      chk("order0", seq[0], 22'h000080);
      chk("order1", seq[1], 22'h3F0201);
      chk("order2", seq[2], 22'h004300);
`endif

      // scroll address changes while the fetch is in flight
      char_cs = 0; obj_cs = 0; scr_cs = 1; scr_addr = 17'h00010;
      #1 m_lat[2] = cur_word(2); m_val[2] = 0; m_ptr = 0;
      wait_req(got);
      chk("chg_req_seen", got, 1'b1);
      chk("chg_addr1", sdram_addr, 22'h004010);
      pulse_ack();
      scr_addr = 17'h00011;
      @(negedge clk);
      pulse_rdy(22'h004010, d);
      m_dat[2] = d; m_val[2] = 1;
      #1 chk("chg_ok", scr_ok, 1'b0);
      check_model("chg");
      transact(0, 0, a);
      chk("chg_addr2", a, 22'h004011);

      // reset in the middle of a char fetch, then a stray rdy
      char_cs = 1; char_addr = 15'h0200;
      #1 m_lat[0] = cur_word(0); m_val[0] = 0;
      chk("pre_rst_scr_ok", scr_ok, 1'b1);
      wait_req(got);
      chk("rst_req_seen", got, 1'b1);
      pulse_ack();
      rst = 1'b1;
      #1 chk("mid_rst_ok", {char_ok, obj_ok, scr_ok}, 3'b000);
      chk("mid_rst_req", sdram_req, 1'b0);
      chk("mid_rst_addr", sdram_addr, 22'h0);
      model_reset();
      char_cs = 0; scr_cs = 0; obj_cs = 0;
      @(negedge clk);
      rst = 1'b0;
      sdram_rdy = 1'b1; sdram_dout = 16'hFFFF;
      @(negedge clk);
      sdram_rdy = 1'b0;
      @(negedge clk);
      chk("stray_req", sdram_req, 1'b0);
      chk("stray_data", {char_data, obj_data, scr_data}, 40'h0);
      scr_cs = 1; scr_addr = 17'h00011;
      #1 chk("stray_scr_ok", scr_ok, 1'b0);
      transact(1, 2, a);
      chk("rst_refetch", a, 22'h004011);

      // randomized traffic against the model
      for (int i = 0; i < 80; i++) begin
         char_cs = ($urandom_range(0, 9) < 7);
         obj_cs  = ($urandom_range(0, 9) < 7);
         scr_cs  = ($urandom_range(0, 9) < 7);
         char_addr = 15'($urandom_range(0, 7));
         scr_addr  = 17'($urandom_range(16, 19));
         case ($urandom_range(0, 2))
            0: obj_addr = 18'h00000;
            1: obj_addr = 18'h00001;
            default: obj_addr = 18'h3FFFF;
         endcase
         check_model("rand_pre");
         transact($urandom_range(0, 3), $urandom_range(0, 3), a);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/jtdd_rom_arb.md
JTDD_ROM_ARB -- requirements
Module: jtdd_rom_arb

Interface
REQ-001 SHALL have parameter CHAR_OFFSET, 22'h00_0000, SDRAM word offset of char ROM.
REQ-002 SHALL have parameter SCR_OFFSET, 22'h00_4000, SDRAM word offset of scroll ROM.
REQ-003 SHALL have parameter OBJ_OFFSET, 22'h02_4000, SDRAM word offset of object ROM.
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports char_addr input 15 byte address; char_cs input 1; char_data output 8; char_ok output 1.
REQ-007 SHALL have ports scr_addr input 17 word address; scr_cs input 1; scr_data output 16; scr_ok output 1.
REQ-008 SHALL have ports obj_addr input 18 word address; obj_cs input 1; obj_data output 16; obj_ok output 1.
REQ-009 SHALL have ports sdram_addr output 22; sdram_req output 1; sdram_ack input 1 (request taken); sdram_rdy input 1 (data valid); sdram_dout input 16.

Function
REQ-010 SHALL keep per requester a latched address, data register and valid flag.
REQ-011 Requester pending SHALL mean cs=1 and (valid=0 or current address != latched address).
REQ-012 x_ok SHALL equal cs & valid & (current address == latched address); cs=0 forces ok=0 without clearing valid.
REQ-013 FSM states SHALL be IDLE, REQ, WAIT.
REQ-014 IDLE: if any pending, grant one, latch its address, clear its valid, drive sdram_addr = offset + word address, go REQ next cycle; else stay.
REQ-015 REQ: sdram_req=1 until the cycle sdram_ack=1, then sdram_req=0 and go WAIT.
REQ-016 WAIT: on sdram_rdy=1 store sdram_dout into granted data register, set valid, go IDLE.
REQ-017 Char word address SHALL be char_addr[14:1]; char_data = char_addr[0] ? data[15:8] : data[7:0] of the latched word.
REQ-018 Address change during REQ/WAIT SHALL not abort; on completion ok stays 0 by REQ-012 and requester re-pends.
REQ-019 sdram_rdy outside WAIT and sdram_ack outside REQ SHALL be ignored.
REQ-020 Offset addition SHALL be 22-bit, wrap modulo 2^22, no overflow flag.
REQ-021 Minimum latency pending -> ok SHALL be 3 cycles (IDLE grant, REQ with ack, WAIT with rdy) plus one registered cycle.
REQ-022 Fixed priority (macro off): char > obj > scr.

Reset
REQ-023 Reset SHALL force IDLE, sdram_req=0, sdram_addr=0, all valid=0, all data=0, all ok=0, round-robin pointer to char, effective immediately even mid-transfer.
REQ-024 A sdram_rdy arriving after reset release for an aborted transfer SHALL be ignored (state is IDLE).

Configuration
REQ-025 Macro JTDD_ROM_RR_EN defined: grant SHALL be round-robin char -> obj -> scr, starting after last granted requester.
REQ-026 Macro JTDD_ROM_RR_EN undefined: fixed priority per REQ-022; pointer logic absent.

Structure
REQ-027 FSM state encoding and default offsets SHALL live in shared package jtdd_pkg.
REQ-028 Per-requester latch/compare/valid logic SHALL be one sub-module jtdd_rom_slot, instantiated three times with width parameters.

Verification
REQ-029 char_cs=1, char_addr=15'h0003, ack 2 cycles after req, rdy 4 cycles later with 16'hA55A -> sdram_addr=22'h000001, char_data=8'hA5, char_ok=1.
REQ-030 All three cs=1 simultaneously, macro off -> grants char, obj, scr in order; macro on after prior obj grant -> scr, char, obj.
REQ-031 scr_addr changed 17'h00010->17'h00011 during WAIT -> scr_ok stays 0, second request issued at SCR_OFFSET+17'h00011.
REQ-032 rst pulsed during WAIT, then stray sdram_rdy -> all ok=0, state IDLE, no data stored.
REQ-033 Same char_addr held, toggle only char_addr[0] -> no new sdram_req, char_data swaps bytes, ok stays 1.
REQ-034 obj_addr=18'h3FFFF with OBJ_OFFSET=22'h3F_0001 -> sdram_addr wraps to 22'h03_0000.
